// File: rtl/key_cond_pkg.sv
// Shared state encoding and 50 MHz default timing for the key conditioner.
package key_cond_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_QUAL   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_QUAL = 2'd3
    } key_state_e;

    localparam int unsigned DEF_NUM_KEYS        = 3;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;   // 100 ms

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, qualify FSM and counter, registered pulses.
// Auto-repeat counter is built only when KEY_REPEAT_EN is defined.
module key_debounce_ch
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_PERIOD == 0 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
        $error("key_debounce_ch: need 0 < REPEAT_PERIOD <= REPEAT_DELAY");
    end

    logic [1:0]       sync_q;
    logic             sync_pressed;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    assign sync_pressed = ~sync_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= '1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_n_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // The edge that leaves IDLE/HELD already counts as the first differing cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sync_pressed) begin
                    state_d = ST_PRESS_QUAL;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_PRESS_QUAL: begin
                if (!sync_pressed) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!sync_pressed) begin
                    state_d = ST_RELEASE_QUAL;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_RELEASE_QUAL: begin
                if (sync_pressed) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef KEY_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             repeat_q, repeat_d;

    // Reloading to DELAY-PERIOD reuses the single DELAY compare for every later pulse.
    always_comb begin
        rpt_d    = rpt_q;
        repeat_d = 1'b0;
        if (state_q == ST_HELD && sync_pressed) begin
            if (rpt_q == RPT_LAST) begin
                repeat_d = 1'b1;
                rpt_d    = RPT_RELOAD;
            end else begin
                rpt_d = rpt_q + RPT_W'(1);
            end
        end else if (state_q != ST_HELD && state_q != ST_RELEASE_QUAL) begin
            rpt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rpt_q    <= '0;
            repeat_q <= 1'b0;
        end else begin
            rpt_q    <= rpt_d;
            repeat_q <= repeat_d;
        end
    end

    assign repeat_o = repeat_q;
`else
    assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Debounced level/press/release (and KEY_REPEAT_EN auto-repeat) for the active-low push keys.
// One independent key_debounce_ch per key.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = DEF_NUM_KEYS,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (reset),
            .key_n_i   (key_n[i]),
            .level_o   (key_level[i]),
            .press_o   (key_press[i]),
            .release_o (key_release[i]),
            .repeat_o  (key_repeat[i])
        );
    end

endmodule
